// File: rtl/regfile_mp.sv
// Multi-port register file: byte-enabled write, write-to-read bypass, busy scoreboard.
// Reads are combinational (0 cycles); reservations are refused via rsv_ok while busy, writes always accepted.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [DATA_W/8-1:0]     wr_be,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic                    rsv_ok,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*DATA_W-1:0] rd_data,
   output logic [NREAD-1:0]        rd_busy,
   output logic [ADDR_W:0]         busy_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NBYTE = DATA_W / 8;

   logic [DEPTH-1:0][DATA_W-1:0] regArray;
   logic [DEPTH-1:0]             busyBits;
   logic [DEPTH-1:0]             nextBusy;
   logic [ADDR_W:0]              busyCount;
   logic [ADDR_W:0]              nextCount;
   logic                         wrHit;
   logic                         rsvSet;

   assign wrHit  = wr_en && (wr_addr != '0);
   assign rsv_ok = rsv_en && ((rsv_addr == '0) || !busyBits[rsv_addr] ||
                              (wr_en && (wr_addr == rsv_addr)));
   assign rsvSet = rsv_ok && (rsv_addr != '0);

   // Reservation is applied after the write clear so a new producer keeps the register busy.
   always_comb begin
      nextBusy = busyBits;
      if (wrHit)
         nextBusy[wr_addr] = 1'b0;
      if (rsvSet)
         nextBusy[rsv_addr] = 1'b1;
      nextBusy[0] = 1'b0;
   end

   always_comb begin
      nextCount = '0;
      for (int i = 0; i < DEPTH; i++)
         nextCount = nextCount + {{ADDR_W{1'b0}}, nextBusy[i]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regArray  <= '0;
         busyBits  <= '0;
         busyCount <= '0;
      end else begin
         for (int r = 1; r < DEPTH; r++) begin
            if (wr_en && (wr_addr == ADDR_W'(r))) begin
               for (int b = 0; b < NBYTE; b++) begin
                  if (wr_be[b])
                     regArray[r][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
         busyBits  <= nextBusy;
         busyCount <= nextCount;
      end
   end

   assign busy_count = busyCount;

   for (genvar p = 0; p < NREAD; p++) begin : gRead
      logic [ADDR_W-1:0] portAddr;
      logic [DATA_W-1:0] portWord;
      logic              portHit;

      assign portAddr = rd_addr[p*ADDR_W +: ADDR_W];
      assign portHit  = wrHit && (wr_addr == portAddr);

      always_comb begin
         portWord = regArray[portAddr];
         for (int b = 0; b < NBYTE; b++) begin
            if (portHit && wr_be[b])
               portWord[8*b +: 8] = wr_data[8*b +: 8];
         end
         if (portAddr == '0)
            portWord = '0;
      end

      assign rd_data[p*DATA_W +: DATA_W] = portWord;
      assign rd_busy[p] = busyBits[portAddr] && !portHit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, hand sequences, then random traffic vs a behavioural model.
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        rsv_ok;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [5:0]  busy_count;

   int errors = 0;
   int checks = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .busy_count(busy_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        re;
      logic [4:0]  ra;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic        eok;
      logic [5:0]  ebc;
   } vec_t;

   vec_t tbl [14];

   // Reference model state
   logic [31:0] mMem  [32];
   bit          mBusy [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1);
      reset    = rst;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      wr_be    = be;
      rsv_en   = re;
      rsv_addr = ra;
      rd_addr  = {a1, a0};
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] mRead(input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0) return 32'd0;
      v = mMem[a];
      if (wr_en && wr_addr == a)
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
      return v;
   endfunction

   function automatic logic mRdBusy(input logic [4:0] a);
      return mBusy[a] && !(wr_en && wr_addr == a && a != 5'd0);
   endfunction

   function automatic logic mRsvOk();
      return rsv_en && (rsv_addr == 5'd0 || !mBusy[rsv_addr] ||
                        (wr_en && wr_addr == rsv_addr));
   endfunction

   function automatic int mCount();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mBusy[i]);
      return n;
   endfunction

   task automatic mClear();
      for (int i = 0; i < 32; i++) begin
         mMem[i]  = 32'd0;
         mBusy[i] = 1'b0;
      end
   endtask

   // Applies the current inputs to the model as the clock edge would.
   task automatic mEdge();
      logic ok;
      ok = mRsvOk();
      if (reset) begin
         mClear();
      end else begin
         if (wr_en && wr_addr != 5'd0) begin
            for (int b = 0; b < 4; b++)
               if (wr_be[b]) mMem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            mBusy[wr_addr] = 1'b0;
         end
         if (ok && rsv_addr != 5'd0)
            mBusy[rsv_addr] = 1'b1;
      end
   endtask

   initial begin
      tbl[0]  = '{1, 5,  32'hDEADBEEF, 4'hF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 6'd0};
      tbl[1]  = '{0, 0,  32'h0,        4'h0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 6'd0};
      tbl[2]  = '{1, 5,  32'h11223344, 4'h5, 0, 0, 5, 5, 32'hDE22BE44, 32'hDE22BE44, 2'b00, 0, 6'd0};
      tbl[3]  = '{0, 0,  32'h0,        4'h0, 0, 0, 5, 0, 32'hDE22BE44, 32'h0,        2'b00, 0, 6'd0};
      tbl[4]  = '{1, 0,  32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 32'h0,        32'h0,        2'b00, 1, 6'd0};
      tbl[5]  = '{0, 0,  32'h0,        4'h0, 1, 7, 7, 0, 32'h0,        32'h0,        2'b00, 1, 6'd0};
      tbl[6]  = '{0, 0,  32'h0,        4'h0, 1, 7, 7, 0, 32'h0,        32'h0,        2'b01, 0, 6'd1};
      tbl[7]  = '{1, 7,  32'hAAAAAAAA, 4'h0, 0, 0, 7, 7, 32'h0,        32'h0,        2'b00, 0, 6'd1};
      tbl[8]  = '{0, 0,  32'h0,        4'h0, 0, 0, 7, 7, 32'h0,        32'h0,        2'b00, 0, 6'd0};
      tbl[9]  = '{0, 0,  32'h0,        4'h0, 1, 9, 9, 9, 32'h0,        32'h0,        2'b00, 1, 6'd0};
      tbl[10] = '{1, 9,  32'h12345678, 4'hF, 1, 9, 9, 9, 32'h12345678, 32'h12345678, 2'b00, 1, 6'd1};
      tbl[11] = '{0, 0,  32'h0,        4'h0, 0, 0, 9, 9, 32'h12345678, 32'h12345678, 2'b11, 0, 6'd1};
      tbl[12] = '{1, 9,  32'h0,        4'h0, 0, 0, 9, 9, 32'h12345678, 32'h12345678, 2'b00, 0, 6'd1};
      tbl[13] = '{0, 0,  32'h0,        4'h0, 0, 0, 9, 9, 32'h12345678, 32'h12345678, 2'b00, 0, 6'd0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();
      drive(0, 0, 0, 0, 0, 0, 0, 5, 9);
      @(negedge clock);
      chk("reset_count", {58'd0, busy_count}, 64'd0);
      chk("reset_data", rd_data, 64'd0);
      chk("reset_busy", {62'd0, rd_busy}, 64'd0);
      nextCycle();

      for (int i = 0; i < 14; i++) begin
         drive(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be,
               tbl[i].re, tbl[i].ra, tbl[i].a0, tbl[i].a1);
         @(negedge clock);
         chk($sformatf("vec%0d_rd0", i), {32'd0, rd_data[31:0]}, {32'd0, tbl[i].e0});
         chk($sformatf("vec%0d_rd1", i), {32'd0, rd_data[63:32]}, {32'd0, tbl[i].e1});
         chk($sformatf("vec%0d_busy", i), {62'd0, rd_busy}, {62'd0, tbl[i].eb});
         chk($sformatf("vec%0d_rsvok", i), {63'd0, rsv_ok}, {63'd0, tbl[i].eok});
         chk($sformatf("vec%0d_count", i), {58'd0, busy_count}, {58'd0, tbl[i].ebc});
         nextCycle();
      end

      // Fill the scoreboard: every nonzero register reserved on consecutive cycles.
      for (int r = 1; r < 32; r++) begin
         drive(0, 0, 0, 0, 0, 1, 5'(r), 0, 0);
         @(negedge clock);
         chk($sformatf("fill_ok%0d", r), {63'd0, rsv_ok}, 64'd1);
         chk($sformatf("fill_cnt%0d", r), {58'd0, busy_count}, 64'(r - 1));
         nextCycle();
      end
      drive(1, 1, 3, 32'hCAFEF00D, 4'hF, 0, 0, 3, 31);
      @(negedge clock);
      chk("full_count", {58'd0, busy_count}, 64'd31);
      chk("full_rd3_bypass", {32'd0, rd_data[31:0]}, 64'hCAFEF00D);
      nextCycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("post_reset_count", {58'd0, busy_count}, 64'd0);
      for (int a = 0; a < 32; a += 2) begin
         rd_addr = {5'(a + 1), 5'(a)};
         #1;
         chk($sformatf("post_reset_data%0d", a), rd_data, 64'd0);
         chk($sformatf("post_reset_busy%0d", a), {62'd0, rd_busy}, 64'd0);
      end
      nextCycle();

      // Randomised traffic on a narrow address window to force collisions.
      mClear();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 1) == 1),
               5'($urandom_range(0, 7)),
               $urandom(),
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) != 0),
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)));
         @(negedge clock);
         chk("rnd_rd0", {32'd0, rd_data[31:0]}, {32'd0, mRead(rd_addr[4:0])});
         chk("rnd_rd1", {32'd0, rd_data[63:32]}, {32'd0, mRead(rd_addr[9:5])});
         chk("rnd_busy", {62'd0, rd_busy},
             {62'd0, mRdBusy(rd_addr[9:5]), mRdBusy(rd_addr[4:0])});
         chk("rnd_rsvok", {63'd0, rsv_ok}, {63'd0, mRsvOk()});
         chk("rnd_count", {58'd0, busy_count}, 64'(mCount()));
         mEdge();
         nextCycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general-purpose register file with byte-enabled writes, same-cycle write-to-read bypass and a per-register busy scoreboard for in-flight producers. It is the successor of the single-width 32x32 register file: it sits between decode (read addresses, reservations) and writeback (write port) in the processor datapath, and it lets decode stall on pending results without a separate scoreboard block. Register 0 reads as zero, ignores writes and is never busy.

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of independent read ports, 1..4

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and busy bits
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
- rsv_en  in  1  reservation request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  combinational; reservation accepted this cycle
- rd_addr  in  NREAD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port p's register has an outstanding producer
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH busy bits; entry 0 is never written and its busy bit is constant 0.
- Write: when wr_en=1 and wr_addr!=0, each byte i with wr_be[i]=1 takes wr_data byte i; bytes with wr_be[i]=0 are unchanged. wr_be=0 gives no data change but still counts as a write for the busy-clear rule below.
- Write clears busy[wr_addr] unless a reservation to the same address is accepted in the same cycle.
- Reservation: rsv_ok = rsv_en & (rsv_addr==0 | ~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr)). An accepted reservation to a nonzero address sets busy[rsv_addr]. Reserving r0 is accepted and has no effect. A rejected reservation changes no state; decode must hold rsv_en and retry.
- Same-cycle write and accepted reservation to the same nonzero address: data is written, and busy ends at 1 because the new producer owns the register.
- Read: combinational. rd_data[p] = 0 if rd_addr[p]==0. Otherwise it is the stored value, with each byte replaced by wr_data when wr_en=1, wr_addr==rd_addr[p] and wr_be set for that byte (bypass).
- rd_busy[p] = busy[rd_addr[p]] & ~(wr_en & wr_addr==rd_addr[p] & wr_addr!=0). A same-cycle reservation does not assert rd_busy until the next cycle.
- busy_count: registered population count of the busy bits, updated in the same edge as the bits, range 0..DEPTH-1.
- Reset: takes priority over wr_en and rsv_en. All registers become 0, all busy bits 0, busy_count 0.

## Timing
- Read latency 0 cycles. A write is visible combinationally through the bypass in cycle N and from the array from cycle N+1.
- A reservation accepted in cycle N gives busy=1 and rd_busy=1 from cycle N+1, and busy_count is incremented at N+1.
- A write in cycle N clears busy at N+1. rd_busy already reads 0 in cycle N via the bypass term.
- rsv_ok has no registered delay and may depend on the same-cycle wr_en/wr_addr.
- Reset mid-operation: state is cleared at the first edge with reset=1. Combinational outputs during the reset cycle reflect pre-reset state plus bypass. After reset deasserts, all reads return 0 and not busy.
- No cycle-to-cycle handshake beyond rsv_en/rsv_ok. Write is always accepted.

## Test plan
- Reset, then write r5=0xDEADBEEF with be=0xF. Read ports 0 and 1 both on r5 in the same cycle -> 0xDEADBEEF (bypass), and next cycle -> 0xDEADBEEF (array).
- r5=0xDEADBEEF, write 0x11223344 with be=0b0101 -> rd_data=0xDE22BE44 in the write cycle and after it.
- Write r0=0xFFFFFFFF, reserve r0 -> rd_data 0, rd_busy 0, rsv_ok=1, busy_count stays 0.
- Reserve r7 -> rsv_ok=1 and busy_count=1 next cycle. Reserve r7 again -> rsv_ok=0. Write r7 with be=0 -> rd_busy=0 in the write cycle, busy_count=0 next cycle.
- With r9 busy, write r9 and reserve r9 in the same cycle -> rsv_ok=1, data updated, busy stays 1, busy_count unchanged.
- Reserve r1..r31 on consecutive cycles -> busy_count=31. Assert reset together with a write r3 -> all reads 0, busy_count 0 next cycle.
